// File: rtl/risk_pkg.sv
// Shared definitions for the RISK command sequencer: function codes, field widths,
// the packed command word and the sequencer state enum.
package risk_pkg;

    localparam int unsigned FUNC_W   = 3;
    localparam int unsigned ADDR_W   = 17;
    localparam int unsigned STRIDE_W = 15;
    localparam int unsigned REG_W    = 5;

    localparam logic [FUNC_W-1:0] FUNC_LOAD  = 3'b000;
    localparam logic [FUNC_W-1:0] FUNC_STORE = 3'b001;
    localparam logic [FUNC_W-1:0] FUNC_ZERO  = 3'b010;
    localparam logic [FUNC_W-1:0] FUNC_NOP   = 3'b111;

    typedef struct packed {
        logic [FUNC_W-1:0]   func;
        logic [REG_W-1:0]    treg;
        logic [ADDR_W-1:0]   addr;
        logic [STRIDE_W-1:0] stride_x;
        logic [STRIDE_W-1:0] stride_y;
    } cmd_t;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StExec,
        StHold
    } state_e;

    function automatic logic func_legal(input logic [FUNC_W-1:0] f);
        return (f == FUNC_LOAD) || (f == FUNC_STORE) || (f == FUNC_ZERO);
    endfunction

endpackage

// File: rtl/risk_cmd_fifo.sv
// Command FIFO for the RISK sequencer: power-of-two depth, one packed word per entry,
// no push/pop bypass when full.
module risk_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_en && !pop_en)      count <= count + CNT_W'(1);
            else if (!push_en && pop_en) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/risk_cmd_seq.sv
// RISK command sequencer: queues tile commands and issues them with load/store timing.
// Optional issue counter enabled by defining RISK_CMD_SEQ_STATS_EN.
module risk_cmd_seq
    import risk_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LOAD_LAT   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [FUNC_W-1:0]   cmd_func,
    input  logic [REG_W-1:0]    cmd_reg,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [STRIDE_W-1:0] cmd_stride_x,
    input  logic [STRIDE_W-1:0] cmd_stride_y,
    output logic [FUNC_W-1:0]   risk_func,
    output logic [REG_W-1:0]    risk_reg,
    output logic [ADDR_W-1:0]   risk_addr,
    output logic [STRIDE_W-1:0] risk_stride_x,
    output logic [STRIDE_W-1:0] risk_stride_y,
    output logic                done,
    output logic                err,
    output logic                busy
`ifdef RISK_CMD_SEQ_STATS_EN
    ,
    output logic [31:0]         issued_cnt
`endif
);

    localparam int unsigned WAIT_W = $clog2(LOAD_LAT + 1);

    state_e            state_q, state_d;
    cmd_t              in_cmd, head, cmd_q;
    logic [WAIT_W-1:0] wait_q;
    logic              fifo_full, fifo_empty;
    logic              push, pop, head_ok;

    always_comb begin
        in_cmd          = '0;
        in_cmd.func     = cmd_func;
        in_cmd.treg     = cmd_reg;
        in_cmd.addr     = cmd_addr;
        in_cmd.stride_x = cmd_stride_x;
        in_cmd.stride_y = cmd_stride_y;
    end

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == StIdle) && !fifo_empty;
    assign head_ok   = func_legal(head.func);

    risk_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(cmd_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (in_cmd),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (pop && head_ok) state_d = (head.func == FUNC_ZERO) ? StExec : StAddr;
            end
            StAddr: begin
                if (wait_q == '0) state_d = StExec;
            end
            StExec: state_d = (cmd_q.func == FUNC_STORE) ? StHold : StIdle;
            StHold: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Illegal commands are dropped without touching the held command fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q  <= '0;
            wait_q <= '0;
        end else if (pop && head_ok) begin
            cmd_q  <= head;
            wait_q <= (head.func == FUNC_LOAD) ? WAIT_W'(LOAD_LAT - 1) : '0;
        end else if ((state_q == StAddr) && (wait_q != '0)) begin
            wait_q <= wait_q - WAIT_W'(1);
        end
    end

    always_comb begin
        risk_func     = (state_q == StExec) ? cmd_q.func : FUNC_NOP;
        risk_reg      = cmd_q.treg;
        risk_addr     = cmd_q.addr;
        risk_stride_x = cmd_q.stride_x;
        risk_stride_y = cmd_q.stride_y;
        done          = ((state_q == StExec) && (cmd_q.func != FUNC_STORE)) ||
                        (state_q == StHold);
        err           = pop && !head_ok;
        busy          = !fifo_empty || (state_q != StIdle);
    end

`ifdef RISK_CMD_SEQ_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  issued_cnt <= '0;
        else if (state_q == StExec) issued_cnt <= issued_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_risk_cmd_seq.sv
// Scoreboard bench for risk_cmd_seq: a cycle-level schedule model predicts every
// issue window, err pulse and FIFO occupancy; a negedge monitor checks the DUT against it.
module tb_risk_cmd_seq;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_func = '0;
    logic [4:0]  cmd_reg = '0;
    logic [16:0] cmd_addr = '0;
    logic [14:0] cmd_stride_x = '0;
    logic [14:0] cmd_stride_y = '0;
    logic [2:0]  risk_func;
    logic [4:0]  risk_reg;
    logic [16:0] risk_addr;
    logic [14:0] risk_stride_x;
    logic [14:0] risk_stride_y;
    logic        done, err, busy;
`ifdef RISK_CMD_SEQ_STATS_EN
    logic [31:0] issued_cnt;
`endif

    risk_cmd_seq #(
        .FIFO_DEPTH (DEPTH),
        .LOAD_LAT   (LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_func      (cmd_func),
        .cmd_reg       (cmd_reg),
        .cmd_addr      (cmd_addr),
        .cmd_stride_x  (cmd_stride_x),
        .cmd_stride_y  (cmd_stride_y),
        .risk_func     (risk_func),
        .risk_reg      (risk_reg),
        .risk_addr     (risk_addr),
        .risk_stride_x (risk_stride_x),
        .risk_stride_y (risk_stride_y),
        .done          (done),
        .err           (err),
        .busy          (busy)
`ifdef RISK_CMD_SEQ_STATS_EN
        ,
        .issued_cnt    (issued_cnt)
`endif
    );

    typedef struct {
        int          start;
        int          exec_c;
        int          last;
        logic [2:0]  func;
        logic [4:0]  treg;
        logic [16:0] addr;
        logic [14:0] sx;
        logic [14:0] sy;
    } win_t;

    win_t   win_q[$];
    int     err_q[$];
    int     acc_a[$], acc_p[$], act_s[$], act_e[$];
    int     cyc = 0;
    int     free_c = 0;
    int     last_p = 0;
    int     checks = 0;
    int     failures = 0;
    longint exp_issued = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Schedule one accepted command: it becomes visible the cycle after acceptance and
    // is popped once the sequencer is free; the rest is fixed latency per function.
    task automatic model_push(input logic [2:0] f, input logic [4:0] r, input logic [16:0] ad,
                              input logic [14:0] sx, input logic [14:0] sy, input int a);
        win_t w;
        int   p;
        p = (a + 1 > free_c) ? a + 1 : free_c;
        last_p = p;
        acc_a.push_back(a);
        acc_p.push_back(p);
        if (f > 3'b010) begin
            err_q.push_back(p);
            act_s.push_back(p + 1);
            act_e.push_back(p);
            free_c = p + 1;
        end else begin
            w.start  = p + 1;
            w.exec_c = (f == 3'b000) ? p + 1 + int'(LAT) : (f == 3'b001) ? p + 2 : p + 1;
            w.last   = (f == 3'b001) ? w.exec_c + 1 : w.exec_c;
            w.func = f; w.treg = r; w.addr = ad; w.sx = sx; w.sy = sy;
            win_q.push_back(w);
            act_s.push_back(w.start);
            act_e.push_back(w.last);
            free_c = w.last + 1;
        end
    endtask

    // Called and returns at posedge+1; leaves cmd_valid low so callers may chain.
    task automatic send(input logic [2:0] f, input logic [4:0] r, input logic [16:0] ad,
                        input logic [14:0] sx, input logic [14:0] sy);
        int bound;
        cmd_valid = 1'b1;
        cmd_func = f; cmd_reg = r; cmd_addr = ad; cmd_stride_x = sx; cmd_stride_y = sy;
        bound = 0;
        while (!cmd_ready && bound < 200) begin
            @(posedge clk); #1;
            bound++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            model_push(f, r, ad, sx, sy, cyc);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc <= free_c + 1) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        cmd_valid = 1'b0;
        win_q.delete(); err_q.delete();
        acc_a.delete(); acc_p.delete(); act_s.delete(); act_e.delete();
        repeat (n) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        free_c = cyc;
    endtask

    logic [2:0] exp_func;
    logic       exp_done, exp_err, exp_busy;
    int         occ;

    always @(negedge clk) begin
        if (reset) begin
            chk("reset_outputs",
                longint'({risk_func, risk_reg, risk_addr, risk_stride_x, risk_stride_y,
                          done, err, busy, cmd_ready}),
                longint'({3'b111, 5'd0, 17'd0, 15'd0, 15'd0, 1'b0, 1'b0, 1'b0, 1'b1}));
`ifdef RISK_CMD_SEQ_STATS_EN
            chk("issued_cnt_reset", longint'(issued_cnt), 0);
`endif
            exp_issued = 0;
        end else begin
            while (win_q.size() > 0 && win_q[0].last < cyc) win_q.delete(0);
            while (err_q.size() > 0 && err_q[0] < cyc) err_q.delete(0);
            exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
            chk("err", longint'(err), longint'(exp_err));
            if (exp_err) err_q.delete(0);
            exp_func = 3'b111;
            exp_done = 1'b0;
            if (win_q.size() > 0 && win_q[0].start <= cyc) begin
                chk("held_fields",
                    longint'({risk_reg, risk_addr, risk_stride_x, risk_stride_y}),
                    longint'({win_q[0].treg, win_q[0].addr, win_q[0].sx, win_q[0].sy}));
                if (win_q[0].exec_c == cyc) exp_func = win_q[0].func;
                exp_done = (win_q[0].last == cyc);
            end
            chk("risk_func", longint'(risk_func), longint'(exp_func));
            chk("done", longint'(done), longint'(exp_done));
            occ = 0;
            exp_busy = 1'b0;
            for (int i = 0; i < acc_a.size(); i++) begin
                if (acc_a[i] < cyc && acc_p[i] >= cyc) occ++;
                if (act_s[i] <= cyc && cyc <= act_e[i]) exp_busy = 1'b1;
            end
            if (occ > 0) exp_busy = 1'b1;
            chk("cmd_ready", longint'(cmd_ready), longint'(occ < int'(DEPTH)));
            chk("busy", longint'(busy), longint'(exp_busy));
`ifdef RISK_CMD_SEQ_STATS_EN
            chk("issued_cnt", longint'(issued_cnt), exp_issued);
`endif
            if (exp_func != 3'b111) exp_issued++;
        end
    end

    initial begin
        int r;
        int gap;
        logic [2:0] f;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        free_c = cyc;
        @(posedge clk); #1;

        send(3'b000, 5'd1, 17'h00100, 15'd1, 15'd16);
        wait_idle();
        send(3'b001, 5'd2, 17'h1FFFF, 15'd3, 15'd4);
        wait_idle();

        // A busy sequencer lets the following five fill the FIFO and stall acceptance.
        send(3'b000, 5'd3, 17'h00200, 15'd2, 15'd2);
        for (int i = 0; i < 5; i++)
            send(3'(i % 3), 5'(i + 8), 17'(17'h01000 + i * 17'h10), 15'(i), 15'(100 + i));
        wait_idle();

        send(3'b101, 5'd9, 17'h0AAAA, 15'd5, 15'd6);
        send(3'b010, 5'd10, 17'h05555, 15'd7, 15'd8);
        wait_idle();

        send(3'b000, 5'd11, 17'h12345, 15'd9, 15'd10);
        while (cyc < last_p + 1) begin
            @(posedge clk); #1;
        end
        do_reset(2);
        send(3'b000, 5'd12, 17'h0ABCD, 15'd11, 15'd12);
        wait_idle();

`ifdef RISK_CMD_SEQ_STATS_EN
        do_reset(1);
        send(3'b001, 5'd1, 17'h00010, 15'd1, 15'd1);
        send(3'b110, 5'd2, 17'h00020, 15'd1, 15'd1);
        send(3'b010, 5'd3, 17'h00030, 15'd1, 15'd1);
        wait_idle();
        chk("issued_cnt_three_cmds", longint'(issued_cnt), 2);
`endif

        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 9));
            f = (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7));
            send(f, 5'($urandom), 17'($urandom), 15'($urandom), 15'($urandom));
            gap = int'($urandom_range(0, 3));
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", longint'(win_q.size() + err_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
